magnitude_comparator: RTL and testbench

//   Registered magnitude comparator for two WIDTH-bit operands.

---
 rtl/magnitude_comparator_pkg.sv | 27 ++
 rtl/magnitude_comparator_if.sv | 36 +++
 rtl/magnitude_comparator_cmp_core.sv | 32 +++
 rtl/magnitude_comparator.sv | 46 ++++
 tb/tb_magnitude_comparator.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/magnitude_comparator_pkg.sv
// Shared types for the registered magnitude comparator: result encoding and flag decode.
// The signed/unsigned choice is made in cmp_core via the CMP_SIGNED_EN macro.
package cmp_pkg;

    localparam int CMP_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        CMP_NONE,
        CMP_EQ,
        CMP_LT,
        CMP_GT
    } cmp_res_t;

    // Returns {ceq, clt, cgt}; CMP_NONE maps to all-zero so the post-reset state has no flag set.
    function automatic logic [2:0] to_flags(input cmp_res_t res);
        logic [2:0] flags;
        flags = 3'b000;
        case (res)
            CMP_EQ:  flags = 3'b100;
            CMP_LT:  flags = 3'b010;
            CMP_GT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/magnitude_comparator_if.sv
// Operand/result bundle for magnitude_comparator.
// in_valid qualifies a/b for one cycle; there is no ready, the comparator accepts every valid
// pair, and out_valid marks the cycle after each accepted pair (flags hold otherwise).
interface magnitude_comparator_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             ceq;
    logic             clt;
    logic             cgt;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  ceq,
        input  clt,
        input  cgt
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output ceq,
        output clt,
        output cgt
    );

endinterface

// File: rtl/magnitude_comparator_cmp_core.sv
// Combinational a-vs-b compare over the full operand width.
// Build with CMP_SIGNED_EN defined for a two's-complement compare; unsigned otherwise.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    logic is_lt;

`ifdef CMP_SIGNED_EN
    assign is_lt = $signed(a) < $signed(b);
`else
    assign is_lt = a < b;
`endif

    always_comb begin
        res = CMP_NONE;
        if (a == b) begin
            res = CMP_EQ;
        end else if (is_lt) begin
            res = CMP_LT;
        end else begin
            res = CMP_GT;
        end
    end

endmodule

// File: rtl/magnitude_comparator.sv
// Registered magnitude comparator: one-hot ceq/clt/cgt one cycle after each valid a/b pair.
// Signed compare when CMP_SIGNED_EN is defined, unsigned otherwise; ports and timing are identical.
module magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    magnitude_comparator_if.slave  bus
);

    logic [WIDTH-1:0] a_qual;
    logic [WIDTH-1:0] b_qual;
    cmp_res_t         core_res;
    cmp_res_t         res_q;
    logic             out_valid_q;

    // Operands are forced to zero when not valid so X on idle inputs never reaches the core.
    assign a_qual = bus.in_valid ? bus.a : '0;
    assign b_qual = bus.in_valid ? bus.b : '0;

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a_qual),
        .b   (b_qual),
        .res (core_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q       <= CMP_NONE;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                res_q <= core_res;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign {bus.ceq, bus.clt, bus.cgt} = to_flags(res_q);

endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed bench for magnitude_comparator at WIDTH=4, including an exhaustive 256-pair sweep.
// Expected values follow CMP_SIGNED_EN so the same bench covers both builds.
module tb_magnitude_comparator;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    magnitude_comparator_if #(.WIDTH(W)) bus ();

    magnitude_comparator #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {out_valid, ceq, clt, cgt} for a captured pair.
    function automatic logic [3:0] ref_out(input int ai, input int bi);
        int sa;
        int sb;
        sa = ai;
        sb = bi;
`ifdef CMP_SIGNED_EN
        if (sa >= (1 << (W - 1))) sa = sa - (1 << W);
        if (sb >= (1 << (W - 1))) sb = sb - (1 << W);
`endif
        if (sa == sb)     return 4'b1100;
        else if (sa < sb) return 4'b1010;
        else              return 4'b1001;
    endfunction

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.out_valid, bus.ceq, bus.clt, bus.cgt};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: {ov,eq,lt,gt} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_onehot(input string tag);
        tests++;
        assert (!bus.out_valid || $onehot({bus.ceq, bus.clt, bus.cgt})) else begin
            fails++;
            $error("FAIL %s: flags observed=%b expected one-hot", tag, {bus.ceq, bus.clt, bus.cgt});
        end
    endtask

    // driver: apply on negedge, sample 1 time unit after the capturing edge
    task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = aa;
        bus.b        = bb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] xa;
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        #2;
        check("reset_state", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0);
        check("idle_after_reset", 4'b0000);

        // Equal
        drive(1'b1, 4'd4, 4'd4);
        check("eq_4_4", 4'b1100);

        // Back-to-back less then greater
        drive(1'b1, 4'd2, 4'd5);
        check("lt_2_5", 4'b1010);
        drive(1'b1, 4'd7, 4'd3);
        check("gt_7_3", 4'b1001);

        // Hold: result sticks, out_valid drops, idle operands (including X) ignored
        drive(1'b0, 4'd1, 4'd9);
        check("hold_change_ab", 4'b0001);
        xa = 'x;
        drive(1'b0, xa, xa);
        check("hold_x_ab", 4'b0001);

        // Extremes
        drive(1'b1, 4'd15, 4'd0);
        check("ext_15_0", ref_out(15, 0));
`ifdef CMP_SIGNED_EN
        check("ext_15_0_signed", 4'b1010);
`else
        check("ext_15_0_unsigned", 4'b1001);
`endif
        drive(1'b1, 4'd0, 4'd0);
        check("ext_0_0", 4'b1100);
        drive(1'b1, 4'd8, 4'd7);
`ifdef CMP_SIGNED_EN
        check("ext_8_7_signed", 4'b1010);
`else
        check("ext_8_7_unsigned", 4'b1001);
`endif

        // Async reset mid-run with flags set, then a capture pending on a reset edge
        drive(1'b1, 4'd6, 4'd6);
        check("pre_reset_eq", 4'b1100);
        bus.in_valid = 1'b1;
        bus.a        = 4'd3;
        bus.b        = 4'd1;
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_clear", 4'b0000);
        @(posedge clk);
        #1;
        check("capture_during_reset", 4'b0000);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset_release", 4'b0000);

        // Exhaustive sweep, back-to-back
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                drive(1'b1, W'(i), W'(j));
                check($sformatf("sweep_%0d_%0d", i, j), ref_out(i, j));
                check_onehot($sformatf("onehot_%0d_%0d", i, j));
            end
        end
        drive(1'b0, 4'd0, 4'd0);
        check("sweep_tail_hold", ref_out((1 << W) - 1, (1 << W) - 1) & 4'b0111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
